// File: rtl/perf_counter_unit_if.sv
// perf_counter_unit_if: fetch-observation and readback bundle for perf_counter_unit.
//   master (core / bench): drives fetch_valid, fetch_opcode, fetch_pc, rd_sel; samples rd_data, halted
//   slave  (counter unit): samples the fetch/readback inputs; drives rd_data, halted
interface perf_counter_unit_if #(parameter int CNT_W = 32);
    logic             fetch_valid;
    logic [6:0]       fetch_opcode;
    logic [31:0]      fetch_pc;
    logic [4:0]       rd_sel;
    logic [CNT_W-1:0] rd_data;
    logic             halted;
    modport master (output fetch_valid, fetch_opcode, fetch_pc, rd_sel, input rd_data, halted);
    modport slave  (input fetch_valid, fetch_opcode, fetch_pc, rd_sel, output rd_data, halted);
endinterface

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: per-class instruction/cycle profiler with halt-loop detection and registered readback.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; zeroes all state including rd_data
//   en    : count enable; 0 freezes counting state
//   clr   : synchronous clear of counters and halt state (rd_data still updates)
//   bus   : perf_counter_unit_if.slave (fetch_valid/opcode/pc, rd_sel in; rd_data, halted out)
//   Build option PERF_SATURATE_EN: counters and adds clamp at all-ones instead of wrapping.
module perf_counter_unit #(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                clr,
    perf_counter_unit_if.slave  bus
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cyc_cnt, instr_cnt, run_cnt, rd_q, rd_next;
    logic [CNT_W-1:0] class_cnt [8];
    logic [CNT_W-1:0] class_cyc [8];
    logic [31:0]      last_pc;
    logic [2:0]       cur_class, f_class, idx;
    logic [1:0]       rep_cnt;
    logic             pending, halted_r, fire, same, halt_now, counted, cnt_cyc;

    function automatic logic [2:0] op_class(input logic [6:0] op);
        return op == 7'b0110011 ? 3'd0 :
               op == 7'b0010011 ? 3'd1 :
               op == 7'b0000011 ? 3'd2 :
               op == 7'b0100011 ? 3'd3 :
               op == 7'b1100011 ? 3'd4 :
               op == 7'b1101111 ? 3'd5 :
               op == 7'b0110111 ? 3'd6 : 3'd7;
    endfunction

    function automatic logic [CNT_W-1:0] add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
`ifdef PERF_SATURATE_EN
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
`else
        return a + b;
`endif
    endfunction

    assign f_class  = op_class(bus.fetch_opcode);
    assign fire     = bus.fetch_valid && en && !halted_r && !clr;
    // pending doubles as "a last PC exists", so PC 0 right after reset is not a repeat
    assign same     = pending && bus.fetch_pc == last_pc;
    // the second consecutive repeat halts; that fetch and its cycle are not counted
    assign halt_now = fire && same && rep_cnt == 2'd1;
    assign counted  = fire && !halt_now;
    assign cnt_cyc  = en && !halted_r && !clr && !halt_now;
    // class_cnt (2..9) and class_cyc (10..17) are 8 apart, so one index serves both
    assign idx      = 3'(bus.rd_sel - 5'd2);

    always_comb begin
        rd_next = '0;
        if (bus.rd_sel == 5'd0) rd_next = cyc_cnt;
        else if (bus.rd_sel == 5'd1) rd_next = instr_cnt;
        else if (bus.rd_sel < 5'd10) rd_next = class_cnt[idx];
        else if (bus.rd_sel < 5'd18) rd_next = class_cyc[idx];
        else if (bus.rd_sel == 5'd18) rd_next = CNT_W'({pending, halted_r});
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
            run_cnt   <= '0;
            rep_cnt   <= '0;
            cur_class <= '0;
            pending   <= 1'b0;
            last_pc   <= '0;
            halted_r  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                class_cnt[i] <= '0;
                class_cyc[i] <= '0;
            end
        end else begin
            if (cnt_cyc) cyc_cnt <= add(cyc_cnt, ONE);
            if (counted) begin
                instr_cnt          <= add(instr_cnt, ONE);
                class_cnt[f_class] <= add(class_cnt[f_class], ONE);
                if (pending) class_cyc[cur_class] <= add(class_cyc[cur_class], run_cnt);
                run_cnt   <= ONE;
                cur_class <= f_class;
                pending   <= 1'b1;
                last_pc   <= bus.fetch_pc;
                rep_cnt   <= same ? rep_cnt + 2'd1 : 2'd0;
            end else if (cnt_cyc) begin
                run_cnt <= add(run_cnt, ONE);
            end
            if (halt_now) halted_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) rd_q <= '0;
        else rd_q <= rd_next;
    end

    assign bus.rd_data = rd_q;
    assign bus.halted  = halted_r;
endmodule

// File: tb/tb_perf_counter_unit.sv
// tb_perf_counter_unit: directed scoreboard bench for perf_counter_unit (32-bit and 4-bit instances).
module tb_perf_counter_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic clr2 = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    perf_counter_unit_if #(.CNT_W(32)) b1();
    perf_counter_unit_if #(.CNT_W(4))  b2();

    perf_counter_unit #(.CNT_W(32)) u1 (.clk(clk), .reset(reset), .en(en), .clr(clr),  .bus(b1.slave));
    perf_counter_unit #(.CNT_W(4))  u2 (.clk(clk), .reset(reset), .en(en), .clr(clr2), .bus(b2.slave));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk();
        exp_t e;
        e = sb.pop_front();
        chk(e.tag, b1.rd_data, e.exp);
    endtask

    task automatic rd(input string tag, input logic [4:0] sel, input logic [31:0] exp);
        b1.rd_sel = sel;
        sb.push_back('{tag, exp});
        tick();
        pop_chk();
    endtask

    task automatic fetch(input logic [6:0] op, input logic [31:0] pc);
        b1.fetch_valid  = 1'b1;
        b1.fetch_opcode = op;
        b1.fetch_pc     = pc;
        tick();
        b1.fetch_valid = 1'b0;
    endtask

    initial begin
        b1.fetch_valid = 1'b0; b1.fetch_opcode = '0; b1.fetch_pc = '0; b1.rd_sel = '0;
        b2.fetch_valid = 1'b0; b2.fetch_opcode = '0; b2.fetch_pc = '0; b2.rd_sel = '0;
        en = 1'b1;
        repeat (2) tick();
        chk("reset_rd_data", b1.rd_data, 32'd0);
        chk("reset_halted", {31'd0, b1.halted}, 32'd0);

        // 4-bit counters: after 21 edges rd_data shows cyc_cnt after 20 counting cycles
        reset = 1'b1;
        repeat (21) tick();
`ifdef PERF_SATURATE_EN
        chk("cntw4_cyc", {28'd0, b2.rd_data}, 32'd15);
`else
        chk("cntw4_cyc", {28'd0, b2.rd_data}, 32'd4);
`endif

        // open a run, then reset mid-instruction with a fetch presented
        fetch(7'b0110011, 32'h100);
        repeat (3) tick();
        reset = 1'b0;
        b1.fetch_valid = 1'b1;
        b1.fetch_opcode = 7'b0110011;
        b1.fetch_pc = 32'h200;
        tick();
        b1.fetch_valid = 1'b0;
        chk("midreset_rd_data", b1.rd_data, 32'd0);
        chk("midreset_halted", {31'd0, b1.halted}, 32'd0);
        reset = 1'b1;

        // class attribution: I-arith at c0, R at c4, repeat PC at c9, halting repeat at c10
        fetch(7'b0010011, 32'h10);
        repeat (3) tick();
        fetch(7'b0110011, 32'h14);
        repeat (4) tick();
        fetch(7'b1101111, 32'h14);
        chk("attr_not_halted", {31'd0, b1.halted}, 32'd0);
        fetch(7'b1101111, 32'h14);
        chk("attr_halted", {31'd0, b1.halted}, 32'd1);
        rd("class_cnt1", 5'd3, 32'd1);
        rd("class_cnt0", 5'd2, 32'd1);
        rd("class_cyc1", 5'd11, 32'd4);
        rd("class_cyc0", 5'd10, 32'd5);
        rd("class_cnt5", 5'd7, 32'd1);
        rd("class_cyc5_open", 5'd15, 32'd0);
        rd("class_cyc2", 5'd12, 32'd0);
        rd("cyc_frozen", 5'd0, 32'd10);
        rd("instr_cnt", 5'd1, 32'd3);
        rd("status", 5'd18, 32'd3);
        rd("sel_unused", 5'd25, 32'd0);

        // clr with a simultaneous fetch; rd_data still captures pre-clear instr_cnt
        clr = 1'b1;
        b1.rd_sel = 5'd1;
        sb.push_back('{"clr_rd_update", 32'd3});
        fetch(7'b0000011, 32'h80);
        clr = 1'b0;
        pop_chk();
        chk("clr_halted", {31'd0, b1.halted}, 32'd0);
        rd("clr_cyc", 5'd0, 32'd0);
        rd("clr_instr", 5'd1, 32'd0);
        rd("clr_status", 5'd18, 32'd0);
        rd("clr_class_cyc0", 5'd10, 32'd0);

        // halt loop: PC 0x40 at c0, c3, c6
        clr = 1'b1;
        tick();
        clr = 1'b0;
        fetch(7'b0000011, 32'h40);
        repeat (2) tick();
        fetch(7'b0000011, 32'h40);
        repeat (2) tick();
        chk("loop_pre_halt", {31'd0, b1.halted}, 32'd0);
        fetch(7'b0000011, 32'h40);
        chk("loop_halted", {31'd0, b1.halted}, 32'd1);
        rd("loop_cyc", 5'd0, 32'd6);
        rd("loop_instr", 5'd1, 32'd2);
        rd("loop_status", 5'd18, 32'd3);
        rd("loop_class_cnt2", 5'd4, 32'd2);
        rd("loop_class_cyc2", 5'd12, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
